fbuf_arb_responder: RTL and testbench
=====================================

Name: fbuf_arb_responder

Overview:
- Memory-side responder for the arbiter request interface driven by the drawing engines (rts/rtr handshake carrying wben, addr, data, op).
- Accepts one request per transfer and turns it into a single-port, byte-enabled frame-buffer SRAM access.
- For reads, returns the read data with a one-cycle transfer-complete strobe.
- Sits between the arbiter output and the frame-buffer SRAM macro.

Parameters:
- RD_LATENCY, 1, SRAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..4.
- ADDR_MAX, 16'hFFFF, highest legal word address; requests above it are out of range.

Ports:
- clk  in  1  system clock
- rst_  in  1  synchronous active-low reset
- req_in_rts  in  1  requester ready-to-send
- req_out_rtr  out  1  responder ready-to-receive
- req_in_wben  in  4  byte write enables; bit i covers data[8i+7:8i]
- req_in_addr  in  16  word address
- req_in_data  in  32  write data
- req_in_op  in  1  0 = write, 1 = read
- rsp_out_data  out  32  read data
- rsp_out_xfc  out  1  one-cycle pulse; rsp_out_data valid
- mem_en  out  1  SRAM access enable
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  16  SRAM address
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data
- err_cnt  out  16  out-of-range access count (see Optional Feature)

Behaviour:
- Clock and reset: single clock clk. Reset rst_ is synchronous and active-low.
- Reset values: req_out_rtr=0, rsp_out_xfc=0, rsp_out_data=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, err_cnt=0, state=IDLE.
- req_out_rtr rises the first cycle after rst_ deasserts.
- Transfer: accept occurs when req_in_rts & req_out_rtr at a rising edge. Request fields are sampled only on accept. No acceptance occurs without rts.
- State IDLE:
  - req_out_rtr=1.
  - Write accepted at edge N: mem_en=1, mem_we=wben, mem_addr=addr, mem_wdata=data during cycle N+1. State stays IDLE, so back-to-back writes sustain one per cycle.
  - Write with wben=0: accepted, but mem_en stays 0 (no access).
  - Read accepted at edge N: mem_en=1, mem_we=0, mem_addr=addr during cycle N+1. req_out_rtr drops for cycle N+1. State goes to RD_WAIT.
- State RD_WAIT:
  - req_out_rtr=0, mem_en=0.
  - A latency counter is loaded with RD_LATENCY and decrements each cycle.
  - When the counter reaches zero, mem_rdata is captured into rsp_out_data. rsp_out_xfc=1 for exactly the cycle N+2+RD_LATENCY. State goes to RD_RESP.
- State RD_RESP: one cycle; rsp_out_xfc=0. Returns to IDLE with req_out_rtr=1.
  - Minimum spacing from one read accept to the next accept is RD_LATENCY+3 cycles.
- Non-access cycles: mem_en and mem_we return to 0 in every cycle without an access. mem_addr and mem_wdata hold their last values.
- rsp_out_data holds its value until the next read completes.
- Out-of-range requests (addr > ADDR_MAX):
  - The request is still accepted, but mem_en stays 0.
  - A read still follows the full RD_WAIT/RD_RESP timing and returns 32'h0.
- Reset mid-read: any pending read is discarded and no rsp_out_xfc is issued. The SRAM's late mem_rdata is ignored.
- Requester dropping rts while rtr=0 is legal and ignored.
- Arithmetic: latency counter is 3 bits. err_cnt is 16 bits and saturates at 16'hFFFF (no wrap).

Optional Feature:
- FBUF_RESP_ERR_CNT_EN
  - Defined: err_cnt increments by 1 on every accepted out-of-range request, read or write, saturating at 16'hFFFF.
  - Undefined: err_cnt is tied to 16'h0 and no counter logic is built.
  - Out-of-range suppression of mem_en applies in both builds.

Decomposition:
- Shared package fbuf_pkg:
  - OP_WRITE=1'b0, OP_READ=1'b1
  - State encodings IDLE/RD_WAIT/RD_RESP
  - FB_ADDR_W=16, FB_DATA_W=32, FB_WBEN_W=4
- Sub-module fbuf_rd_pipe: latency counter plus capture register, producing rsp_out_data and rsp_out_xfc. Parameterized by RD_LATENCY.

Test Plan:
- Reset release -> all outputs 0 during reset; req_out_rtr=1 on the first cycle after release.
- Write addr=16'h0010, data=32'h00A5B6C7, wben=4'b0111, accepted at edge N -> during cycle N+1: mem_en=1, mem_we=4'b0111, mem_addr=16'h0010, mem_wdata=32'h00A5B6C7. A further write at N+1 is also accepted, with req_out_rtr staying 1.
- Read addr=16'h0010, RD_LATENCY=2, accepted at edge N, SRAM model returns 32'h00A5B6C7 -> during cycle N+1: mem_en=1, mem_we=0. req_out_rtr=0 from N+1 to N+4. During cycle N+4: rsp_out_xfc=1 and rsp_out_data=32'h00A5B6C7. During cycle N+5: req_out_rtr=1.
- ADDR_MAX=16'h7FFF; write to 16'h8000, then read of 16'h8000 -> mem_en never asserts. Read returns 32'h0 with normal timing. err_cnt=2 with FBUF_RESP_ERR_CNT_EN defined, 0 without.
- rst_ asserted during RD_WAIT -> rsp_out_xfc never pulses, state is IDLE; after release, a new read completes correctly.
- Write with wben=4'b0000 -> accepted (req_out_rtr stays 1), mem_en stays 0.

Source files
------------

// File: rtl/fbuf_pkg.sv
// fbuf_pkg: widths, opcode values and FSM state encoding shared by the
// frame-buffer responder and its read pipe.
package fbuf_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 32;
  localparam int FB_WBEN_W = 4;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } fbuf_state_t;

endpackage

// File: rtl/fbuf_rd_pipe.sv
// fbuf_rd_pipe: waits RD_LATENCY cycles after a read is issued to the SRAM,
// captures the returned word and emits a one-cycle transfer-complete strobe.
// Out-of-range reads return zero instead of whatever the SRAM presents.
module fbuf_rd_pipe
  import fbuf_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 start,
  input  logic                 oor,
  input  logic [FB_DATA_W-1:0] mem_rdata,
  output logic                 rd_done,
  output logic [FB_DATA_W-1:0] rsp_out_data,
  output logic                 rsp_out_xfc
);

  logic [2:0] lat_cnt;
  logic       busy;
  logic       oor_q;

  assign rd_done = busy && (lat_cnt == 3'd0);

  // Count down the SRAM latency, then capture the read word and pulse xfc.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      lat_cnt      <= 3'd0;
      busy         <= 1'b0;
      oor_q        <= 1'b0;
      rsp_out_data <= '0;
      rsp_out_xfc  <= 1'b0;
    end else begin
      rsp_out_xfc <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        lat_cnt <= 3'(RD_LATENCY);
        oor_q   <= oor;
      end else if (busy) begin
        if (lat_cnt == 3'd0) begin
          busy         <= 1'b0;
          rsp_out_xfc  <= 1'b1;
          rsp_out_data <= oor_q ? '0 : mem_rdata;
        end else begin
          lat_cnt <= lat_cnt - 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fbuf_arb_responder.sv
// fbuf_arb_responder: memory-side responder for the drawing-engine arbiter.
// Each accepted request becomes one byte-enabled access to the single-port
// frame-buffer SRAM; reads stall the requester until the response strobe.
// Optional macro FBUF_RESP_ERR_CNT_EN builds a saturating out-of-range
// request counter on err_cnt; without it err_cnt is constant zero.
module fbuf_arb_responder
  import fbuf_pkg::*;
#(
  parameter int                   RD_LATENCY = 1,
  parameter logic [FB_ADDR_W-1:0] ADDR_MAX   = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_,
  input  logic                 req_in_rts,
  output logic                 req_out_rtr,
  input  logic [FB_WBEN_W-1:0] req_in_wben,
  input  logic [FB_ADDR_W-1:0] req_in_addr,
  input  logic [FB_DATA_W-1:0] req_in_data,
  input  logic                 req_in_op,
  output logic [FB_DATA_W-1:0] rsp_out_data,
  output logic                 rsp_out_xfc,
  output logic                 mem_en,
  output logic [FB_WBEN_W-1:0] mem_we,
  output logic [FB_ADDR_W-1:0] mem_addr,
  output logic [FB_DATA_W-1:0] mem_wdata,
  input  logic [FB_DATA_W-1:0] mem_rdata,
  output logic [15:0]          err_cnt
);

  fbuf_state_t state;
  fbuf_state_t state_nxt;
  logic        accept;
  logic        is_read;
  logic        addr_oor;
  logic        rd_done;

  assign accept   = req_in_rts && req_out_rtr;
  assign is_read  = (req_in_op == OP_READ);
  assign addr_oor = {1'b0, req_in_addr} > {1'b0, ADDR_MAX};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a read parks the FSM until the pipe delivers the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_read) state_nxt = RD_WAIT;
      RD_WAIT: if (rd_done) state_nxt = RD_RESP;
      RD_RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready-to-receive is high exactly in the cycles the FSM sits in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      req_out_rtr <= 1'b0;
    end else begin
      req_out_rtr <= (state_nxt == IDLE);
    end
  end

  // Drive one SRAM access per accepted in-range request; address and write
  // data keep their last values on idle cycles.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= '0;
      if (accept && !addr_oor) begin
        if (is_read) begin
          mem_en   <= 1'b1;
          mem_addr <= req_in_addr;
        end else if ((req_in_op == OP_WRITE) && (req_in_wben != '0)) begin
          mem_en    <= 1'b1;
          mem_we    <= req_in_wben;
          mem_addr  <= req_in_addr;
          mem_wdata <= req_in_data;
        end
      end
    end
  end

  fbuf_rd_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk          (clk),
    .rst_         (rst_),
    .start        (accept && is_read),
    .oor          (addr_oor),
    .mem_rdata    (mem_rdata),
    .rd_done      (rd_done),
    .rsp_out_data (rsp_out_data),
    .rsp_out_xfc  (rsp_out_xfc)
  );

`ifdef FBUF_RESP_ERR_CNT_EN
  // Count accepted out-of-range requests, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      err_cnt <= 16'h0;
    end else if (accept && addr_oor && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'h1;
    end
  end
`else
  assign err_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_fbuf_arb_responder.sv
// tb_fbuf_arb_responder: directed and randomized bench for the frame-buffer
// responder (RD_LATENCY=2, ADDR_MAX=16'h7FFF). A behavioural SRAM drives
// mem_rdata; a transaction-level model predicts every output each cycle.
// Honors FBUF_RESP_ERR_CNT_EN for the expected err_cnt.
module tb_fbuf_arb_responder;

  localparam int          TB_RD_LAT   = 2;
  localparam logic [15:0] TB_ADDR_MAX = 16'h7FFF;
`ifdef FBUF_RESP_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_;
  logic        req_in_rts;
  logic        req_out_rtr;
  logic [3:0]  req_in_wben;
  logic [15:0] req_in_addr;
  logic [31:0] req_in_data;
  logic        req_in_op;
  logic [31:0] rsp_out_data;
  logic        rsp_out_xfc;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] err_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  fbuf_arb_responder #(
    .RD_LATENCY (TB_RD_LAT),
    .ADDR_MAX   (TB_ADDR_MAX)
  ) dut (
    .clk          (clk),
    .rst_         (rst_),
    .req_in_rts   (req_in_rts),
    .req_out_rtr  (req_out_rtr),
    .req_in_wben  (req_in_wben),
    .req_in_addr  (req_in_addr),
    .req_in_data  (req_in_data),
    .req_in_op    (req_in_op),
    .rsp_out_data (rsp_out_data),
    .rsp_out_xfc  (rsp_out_xfc),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .err_cnt      (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Byte-lane merge used by both the SRAM and the reference memory.
  function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                             input logic [31:0] d,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural SRAM with TB_RD_LAT cycles of read latency; filler words
  // appear on non-read cycles so a mistimed capture is visible.
  logic [31:0] sram    [0:65535];
  logic [31:0] ref_mem [0:65535];
  logic [31:0] rd_stage0;
  logic [31:0] rd_stage1;
  assign mem_rdata = rd_stage1;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = {16'(i), 16'(i) ^ 16'h5A5A};
      ref_mem[i] = {16'(i), 16'(i) ^ 16'h5A5A};
    end
    rd_stage0 = 32'h0;
    rd_stage1 = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en && (mem_we == 4'h0)) rd_stage0 <= sram[mem_addr];
      else rd_stage0 <= $urandom;
      rd_stage1 <= rd_stage0;
      if (mem_en) sram[mem_addr] = mergeBytes(sram[mem_addr], mem_wdata, mem_we);
    end
  end

  // Transaction-level model: values expected in the cycle after each edge.
  logic        model_valid = 1'b0;
  logic        m_rtr, m_en, m_xfc;
  logic [3:0]  m_we;
  logic [15:0] m_addr, m_err;
  logic [31:0] m_wdata, m_data, rd_data;
  logic        pending;
  int          cyc = 0;
  int          xfc_cyc = 0;

  task automatic modelStep();
    logic acc;
    logic oor;
    cyc++;
    if (!rst_) begin
      m_rtr = 1'b0; m_en = 1'b0; m_we = 4'h0; m_addr = 16'h0; m_wdata = 32'h0;
      m_xfc = 1'b0; m_data = 32'h0; m_err = 16'h0; pending = 1'b0; rd_data = 32'h0;
    end else begin
      acc   = req_in_rts && m_rtr;
      m_en  = 1'b0;
      m_we  = 4'h0;
      m_xfc = 1'b0;
      if (acc) begin
        oor = req_in_addr > TB_ADDR_MAX;
        if (oor && ERR_EN && (m_err != 16'hFFFF)) m_err = m_err + 16'h1;
        if (req_in_op == 1'b0) begin
          if (!oor && (req_in_wben != 4'h0)) begin
            m_en = 1'b1; m_we = req_in_wben; m_addr = req_in_addr; m_wdata = req_in_data;
            ref_mem[req_in_addr] = mergeBytes(ref_mem[req_in_addr], req_in_data, req_in_wben);
          end
        end else begin
          if (!oor) begin
            m_en = 1'b1; m_addr = req_in_addr;
          end
          pending = 1'b1;
          xfc_cyc = cyc + 1 + TB_RD_LAT;
          rd_data = oor ? 32'h0 : ref_mem[req_in_addr];
        end
      end
      if (pending && (cyc == xfc_cyc)) begin
        m_xfc  = 1'b1;
        m_data = rd_data;
      end
      if (pending && (cyc > xfc_cyc)) pending = 1'b0;
      m_rtr = !pending;
    end
    model_valid = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Compare every DUT output against the model in the middle of each cycle.
  initial forever begin
    @(negedge clk);
    if (model_valid) begin
      checkOutput("cyc_rtr",   32'(req_out_rtr),  32'(m_rtr));
      checkOutput("cyc_xfc",   32'(rsp_out_xfc),  32'(m_xfc));
      checkOutput("cyc_rdata", rsp_out_data,      m_data);
      checkOutput("cyc_en",    32'(mem_en),       32'(m_en));
      checkOutput("cyc_we",    32'(mem_we),       32'(m_we));
      checkOutput("cyc_addr",  32'(mem_addr),     32'(m_addr));
      checkOutput("cyc_wdata", mem_wdata,         m_wdata);
      checkOutput("cyc_err",   32'(err_cnt),      32'(m_err));
    end
  end

  // Drive one cycle of request inputs; returns just after the edge that
  // sampled them, so the caller sees that edge's results.
  task automatic applyStimulus(input logic rts, input logic op, input logic [3:0] wben,
                               input logic [15:0] addr, input logic [31:0] data);
    req_in_rts  = rts;
    req_in_op   = op;
    req_in_wben = wben;
    req_in_addr = addr;
    req_in_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic stepIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
  endtask

  initial begin
    logic [15:0] ra;
    int          sel;
    rst_ = 1'b0;
    req_in_rts = 1'b0; req_in_op = 1'b0; req_in_wben = 4'h0;
    req_in_addr = 16'h0; req_in_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rtr",   32'(req_out_rtr), 32'h0);
    checkOutput("rst_xfc",   32'(rsp_out_xfc), 32'h0);
    checkOutput("rst_rdata", rsp_out_data,     32'h0);
    checkOutput("rst_en",    32'(mem_en),      32'h0);
    checkOutput("rst_we",    32'(mem_we),      32'h0);
    checkOutput("rst_addr",  32'(mem_addr),    32'h0);
    checkOutput("rst_wdata", mem_wdata,        32'h0);
    checkOutput("rst_err",   32'(err_cnt),     32'h0);
    rst_ = 1'b1;
    checkOutput("rtr_before_release_edge", 32'(req_out_rtr), 32'h0);
    stepIdle(1);
    checkOutput("rtr_after_release", 32'(req_out_rtr), 32'h1);

    // Back-to-back writes, then a write with no byte enables.
    applyStimulus(1'b1, 1'b0, 4'b0111, 16'h0010, 32'h00A5B6C7);
    checkOutput("wr1_en",    32'(mem_en),      32'h1);
    checkOutput("wr1_we",    32'(mem_we),      32'h7);
    checkOutput("wr1_addr",  32'(mem_addr),    32'h0010);
    checkOutput("wr1_wdata", mem_wdata,        32'h00A5B6C7);
    checkOutput("wr1_rtr",   32'(req_out_rtr), 32'h1);
    applyStimulus(1'b1, 1'b0, 4'b1000, 16'h0011, 32'hDEADBEEF);
    checkOutput("wr2_en",    32'(mem_en),      32'h1);
    checkOutput("wr2_we",    32'(mem_we),      32'h8);
    checkOutput("wr2_addr",  32'(mem_addr),    32'h0011);
    applyStimulus(1'b1, 1'b0, 4'b0000, 16'h0012, 32'h12345678);
    checkOutput("wr0_en",    32'(mem_en),      32'h0);
    checkOutput("wr0_rtr",   32'(req_out_rtr), 32'h1);
    checkOutput("wr0_addr_hold",  32'(mem_addr), 32'h0011);
    checkOutput("wr0_wdata_hold", mem_wdata,      32'hDEADBEEF);

    // Read timing with latency 2.
    applyStimulus(1'b1, 1'b1, 4'h0, 16'h0010, 32'h0);
    checkOutput("rd_en",   32'(mem_en),      32'h1);
    checkOutput("rd_we",   32'(mem_we),      32'h0);
    checkOutput("rd_rtr1", 32'(req_out_rtr), 32'h0);
    stepIdle(1);
    checkOutput("rd_rtr2", 32'(req_out_rtr), 32'h0);
    checkOutput("rd_xfc2", 32'(rsp_out_xfc), 32'h0);
    stepIdle(1);
    checkOutput("rd_xfc3", 32'(rsp_out_xfc), 32'h0);
    stepIdle(1);
    checkOutput("rd_xfc4",  32'(rsp_out_xfc), 32'h1);
    checkOutput("rd_data4", rsp_out_data,     32'h00A5B6C7);
    checkOutput("rd_rtr4",  32'(req_out_rtr), 32'h0);
    stepIdle(1);
    checkOutput("rd_rtr5",  32'(req_out_rtr), 32'h1);
    checkOutput("rd_xfc5",  32'(rsp_out_xfc), 32'h0);
    checkOutput("rd_hold5", rsp_out_data,     32'h00A5B6C7);

    // Range boundary: last legal word, then out-of-range write and read.
    applyStimulus(1'b1, 1'b0, 4'b0001, 16'h7FFF, 32'h000000AB);
    checkOutput("edge_en",   32'(mem_en),   32'h1);
    checkOutput("edge_addr", 32'(mem_addr), 32'h7FFF);
    applyStimulus(1'b1, 1'b0, 4'b1111, 16'h8000, 32'hCAFEF00D);
    checkOutput("oor_wr_en", 32'(mem_en), 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0, 16'h8000, 32'h0);
    checkOutput("oor_rd_en",  32'(mem_en),      32'h0);
    checkOutput("oor_rd_rtr", 32'(req_out_rtr), 32'h0);
    stepIdle(3);
    checkOutput("oor_rd_xfc",  32'(rsp_out_xfc), 32'h1);
    checkOutput("oor_rd_data", rsp_out_data,     32'h0);
    stepIdle(1);
    checkOutput("oor_rd_rtr5", 32'(req_out_rtr), 32'h1);
    checkOutput("oor_err_cnt", 32'(err_cnt), ERR_EN ? 32'd2 : 32'd0);

    // Reset while a read is outstanding, then a clean read.
    applyStimulus(1'b1, 1'b1, 4'h0, 16'h0011, 32'h0);
    stepIdle(1);
    rst_ = 1'b0;
    stepIdle(1);
    checkOutput("mid_rst_xfc1", 32'(rsp_out_xfc), 32'h0);
    stepIdle(1);
    checkOutput("mid_rst_xfc2", 32'(rsp_out_xfc), 32'h0);
    checkOutput("mid_rst_rtr",  32'(req_out_rtr), 32'h0);
    rst_ = 1'b1;
    stepIdle(1);
    checkOutput("post_rst_rtr", 32'(req_out_rtr), 32'h1);
    checkOutput("post_rst_xfc", 32'(rsp_out_xfc), 32'h0);
    stepIdle(2);
    checkOutput("post_rst_xfc_late", 32'(rsp_out_xfc), 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0, 16'h0011, 32'h0);
    stepIdle(3);
    checkOutput("rerd_xfc",  32'(rsp_out_xfc), 32'h1);
    checkOutput("rerd_data", rsp_out_data,     32'hDE115A4B);
    stepIdle(1);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        2:       ra = 16'($urandom_range(32'h8001, 32'hFFFF));
        default: ra = 16'($urandom_range(0, 31));
      endcase
      rst_ = ($urandom_range(0, 249) != 0);
      applyStimulus($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), ra, $urandom);
    end
    rst_ = 1'b1;
    stepIdle(8);

    $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
